hazard_stall_ctrl: RTL and testbench

- Companion to the pipeline forwarding logic. It covers hazards that forwarding cannot resolve: load-use stalls, taken-branch flushes and data-memory wait states.
- Sits beside the 5-stage datapath and drives stall/flush enables into the IF/ID, ID/EX and EX/MEM pipeline registers.
- Contains a memory-wait FSM with a watchdog, and saturating stall/flush statistics counters readable by debug logic.

---
 rtl/hazard_stall_ctrl_if.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 76 +++++++
 tb/tb_hazard_stall_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard inputs from the datapath and the stall/flush enables returned to it
interface hazard_stall_ctrl_if;
  logic       MemReadE;
  logic [4:0] RD_E;
  logic [4:0] Rs1_D;
  logic [4:0] Rs2_D;
  logic       Rs1Used_D;
  logic       Rs2Used_D;
  logic       PCSrcE;
  logic       MemBusyM;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  modport master (
    output MemReadE, RD_E, Rs1_D, Rs2_D, Rs1Used_D, Rs2Used_D, PCSrcE, MemBusyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE
  );
  modport slave (
    input  MemReadE, RD_E, Rs1_D, Rs2_D, Rs1Used_D, Rs2Used_D, PCSrcE, MemBusyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, branch flush and memory-wait control with watchdog and stall/flush statistics
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   hz,
  input  logic                 clr_cnt,
  output logic                 mem_fault,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);
  typedef enum logic [1:0] {RUN, MWAIT, FAULT} state_t;
  state_t           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             mem_fault_q, mem_fault_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lu_hazard, frozen, stall_all, br_flush, lu_stall;
  assign lu_hazard = hz.MemReadE && hz.RD_E != 5'd0 &&
                     ((hz.Rs1Used_D && hz.RD_E == hz.Rs1_D) || (hz.Rs2Used_D && hz.RD_E == hz.Rs2_D));
  // MWAIT with MemBusyM low decodes as RUN, so only busy or FAULT freeze the pipe
  assign frozen    = hz.MemBusyM || state_q == FAULT;
  assign stall_all = rst && frozen;
  assign br_flush  = rst && !frozen && hz.PCSrcE;
  assign lu_stall  = rst && !frozen && !hz.PCSrcE && lu_hazard;
  assign hz.StallF = stall_all || lu_stall;
  assign hz.StallD = stall_all || lu_stall;
  assign hz.StallE = stall_all;
  assign hz.StallM = stall_all;
  assign hz.FlushD = br_flush;
  assign hz.FlushE = br_flush || lu_stall;
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_fault_d = clr_cnt ? 1'b0 : mem_fault_q;
    case (state_q)
      RUN: if (hz.MemBusyM) begin
        state_d = MWAIT;
        wcnt_d  = 8'd1;
      end
      MWAIT: if (!hz.MemBusyM) begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end else if (wcnt_q == 8'(TIMEOUT)) begin
        state_d     = FAULT;
        wcnt_d      = 8'd0;
        mem_fault_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 8'd1;
      end
      FAULT: state_d = clr_cnt ? RUN : FAULT;
      default: state_d = RUN;
    endcase
    stall_cnt_d = clr_cnt ? '0 : (hz.StallF && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = clr_cnt ? '0 : ((hz.FlushD || hz.FlushE) && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wcnt_q      <= 8'd0;
      mem_fault_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_fault_q <= mem_fault_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign mem_fault = mem_fault_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random checks of hazard_stall_ctrl against a behavioural model
module tb_hazard_stall_ctrl;
  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_cnt = 1'b0;
  logic mem_fault;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0;
  int errors = 0;
  bit m_fault;
  int m_streak, m_sc, m_fc;
  bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe;
  hazard_stall_ctrl_if hz_if ();
  hazard_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hz(hz_if), .clr_cnt(clr_cnt),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_in(input bit mr, input int rd, input int r1, input int r2,
                        input bit u1, input bit u2, input bit br, input bit busy, input bit clr);
    hz_if.MemReadE = mr; hz_if.RD_E = 5'(rd); hz_if.Rs1_D = 5'(r1); hz_if.Rs2_D = 5'(r2);
    hz_if.Rs1Used_D = u1; hz_if.Rs2Used_D = u2; hz_if.PCSrcE = br; hz_if.MemBusyM = busy;
    clr_cnt = clr;
  endtask
  task automatic model_reset();
    m_fault = 0; m_streak = 0; m_sc = 0; m_fc = 0;
  endtask
  task automatic cycle();
    bit lu;
    @(negedge clk);
    lu = hz_if.MemReadE && hz_if.RD_E != 0 &&
         ((hz_if.Rs1Used_D && hz_if.RD_E == hz_if.Rs1_D) || (hz_if.Rs2Used_D && hz_if.RD_E == hz_if.Rs2_D));
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe} = 6'b000000;
    if (hz_if.MemBusyM || m_fault) {e_sf, e_sd, e_se, e_sm} = 4'b1111;
    else if (hz_if.PCSrcE) {e_fd, e_fe} = 2'b11;
    else if (lu) {e_sf, e_sd, e_fe} = 3'b111;
    chk("StallF", hz_if.StallF, e_sf);
    chk("StallD", hz_if.StallD, e_sd);
    chk("StallE", hz_if.StallE, e_se);
    chk("StallM", hz_if.StallM, e_sm);
    chk("FlushD", hz_if.FlushD, e_fd);
    chk("FlushE", hz_if.FlushE, e_fe);
    @(posedge clk);
    if (m_fault) begin
      if (clr_cnt) begin m_fault = 0; m_streak = 0; end
    end else if (hz_if.MemBusyM) begin
      if (m_streak == TO) begin m_fault = 1; m_streak = 0; end
      else m_streak++;
    end else m_streak = 0;
    m_sc = clr_cnt ? 0 : (e_sf && m_sc < MAX) ? m_sc + 1 : m_sc;
    m_fc = clr_cnt ? 0 : ((e_fd || e_fe) && m_fc < MAX) ? m_fc + 1 : m_fc;
    #1;
    chk("mem_fault", mem_fault, m_fault);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
  endtask
  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    model_reset();
    #3;
    chk("rst_StallF", hz_if.StallF, 0);
    chk("rst_StallM", hz_if.StallM, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    @(negedge clk) rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk) #1;
    // load-use: one bubble
    set_in(1, 5, 3, 5, 1, 1, 0, 0, 0); cycle();
    chk("lu_scnt", stall_cnt, 1);
    chk("lu_fcnt", flush_cnt, 1);
    set_in(0, 5, 3, 5, 1, 1, 0, 0, 0); cycle();
    // x0 destination and unused source
    set_in(1, 0, 0, 0, 1, 1, 0, 0, 0); cycle();
    set_in(1, 7, 7, 1, 0, 1, 0, 0, 0); cycle();
    chk("x0_scnt", stall_cnt, 1);
    // branch beats load-use
    set_in(1, 9, 9, 0, 1, 0, 1, 0, 0); cycle();
    chk("br_FlushD", hz_if.FlushD, 1);
    chk("br_StallF", hz_if.StallF, 0);
    // memory wait with a taken branch pending
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    for (int i = 0; i < 3; i++) begin set_in(1, 4, 4, 4, 1, 1, 1, 1, 0); cycle(); end
    chk("mw_scnt", stall_cnt, 3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    // watchdog
    for (int i = 0; i < TO + 1; i++) begin set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); cycle(); end
    chk("wd_fault", mem_fault, 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
    chk("wd_hold_StallM", hz_if.StallM, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    chk("wd_clr_fault", mem_fault, 0);
    chk("wd_clr_scnt", stall_cnt, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("wd_run_StallF", hz_if.StallF, 0);
    // asynchronous reset in the middle of a wait
    for (int i = 0; i < 2; i++) begin set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); cycle(); end
    #2 rst = 1'b0;
    #1;
    chk("arst_StallF", hz_if.StallF, 0);
    chk("arst_StallE", hz_if.StallE, 0);
    chk("arst_scnt", stall_cnt, 0);
    model_reset();
    @(posedge clk) #1 rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("arst_run_StallM", hz_if.StallM, 0);
    // counter saturation through load-use stalls
    for (int i = 0; i < 20; i++) begin set_in(1, 3, 3, 0, 1, 0, 0, 0, 0); cycle(); end
    chk("sat_scnt", stall_cnt, MAX);
    chk("sat_fcnt", flush_cnt, MAX);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
